// File: rtl/id_pkg.sv
// Shared constants for the identifier scanner: FSM state encoding, character
// class codes and the ASCII ranges that define them.
package id_pkg;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ALPHA = 2'd1;
    localparam logic [1:0] S_DIGIT = 2'd2;
    localparam logic [1:0] S_SKIP  = 2'd3;

    localparam logic [1:0] CLS_OTHER = 2'd0;
    localparam logic [1:0] CLS_DIGIT = 2'd1;
    localparam logic [1:0] CLS_ALPHA = 2'd2;

    localparam logic [7:0] ASCII_0    = 8'h30;
    localparam logic [7:0] ASCII_9    = 8'h39;
    localparam logic [7:0] ASCII_UC_A = 8'h41;
    localparam logic [7:0] ASCII_UC_Z = 8'h5A;
    localparam logic [7:0] ASCII_LC_A = 8'h61;
    localparam logic [7:0] ASCII_LC_Z = 8'h7A;

endpackage

// File: rtl/id_scanner_char_class.sv
// Combinational character classifier: maps an ASCII byte to DIGIT, ALPHA or
// OTHER.
module char_class
    import id_pkg::*;
(
    input  logic [7:0] char,
    output logic [1:0] cls
);

    always_comb begin
        cls = CLS_OTHER;
        if (char >= ASCII_0 && char <= ASCII_9)
            cls = CLS_DIGIT;
        else if ((char >= ASCII_UC_A && char <= ASCII_UC_Z) ||
                 (char >= ASCII_LC_A && char <= ASCII_LC_Z))
            cls = CLS_ALPHA;
    end

endmodule

// File: rtl/id_scanner.sv
// Streaming scanner for letters-then-digits identifiers: flags each extending
// digit, reports token length on termination and keeps a saturating count.
module id_scanner
    import id_pkg::*;
#(
    parameter int LEN_W  = 6,
    parameter int CNT_W  = 16,
    parameter int STRICT = 0
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [7:0]       char,
    input  logic             char_valid,
    input  logic             cnt_clr,
    output logic             out,
    output logic             tok_done,
    output logic [LEN_W-1:0] tok_len,
    output logic [CNT_W-1:0] tok_cnt
);

    function automatic logic [LEN_W-1:0] len_sat_inc(input logic [LEN_W-1:0] v);
        return (&v) ? v : v + LEN_W'(1);
    endfunction

    function automatic logic [CNT_W-1:0] cnt_sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + CNT_W'(1);
    endfunction

    logic [1:0]       cls;
    logic [1:0]       state_p0;
    logic [1:0]       state_nxt;
    logic [LEN_W-1:0] run_len_p0;
    logic             out_nxt;
    logic             done_nxt;
    logic             len_load;
    logic             len_inc;

    char_class u_char_class (
        .char (char),
        .cls  (cls)
    );

    always_comb begin
        state_nxt = state_p0;
        out_nxt   = 1'b0;
        done_nxt  = 1'b0;
        len_load  = 1'b0;
        len_inc   = 1'b0;
        case (state_p0)
            S_IDLE: begin
                if (cls == CLS_ALPHA) begin
                    state_nxt = S_ALPHA;
                    len_load  = 1'b1;
                end else if (cls == CLS_DIGIT && STRICT != 0) begin
                    state_nxt = S_SKIP;
                end
            end
            S_ALPHA: begin
                if (cls == CLS_ALPHA) begin
                    len_inc = 1'b1;
                end else if (cls == CLS_DIGIT) begin
                    state_nxt = S_DIGIT;
                    out_nxt   = 1'b1;
                    len_inc   = 1'b1;
                end else begin
                    state_nxt = S_IDLE;
                end
            end
            S_DIGIT: begin
                if (cls == CLS_DIGIT) begin
                    out_nxt = 1'b1;
                    len_inc = 1'b1;
                end else begin
                    // Any non-digit closes the token; a letter may open the next one.
                    done_nxt = 1'b1;
                    if (cls == CLS_OTHER) begin
                        state_nxt = S_IDLE;
                    end else if (STRICT != 0) begin
                        state_nxt = S_SKIP;
                    end else begin
                        state_nxt = S_ALPHA;
                        len_load  = 1'b1;
                    end
                end
            end
            default: begin
                if (cls == CLS_OTHER)
                    state_nxt = S_IDLE;
            end
        endcase
    end

    // Registered stage: state, run length and all outputs
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p0   <= S_IDLE;
            run_len_p0 <= '0;
            out        <= 1'b0;
            tok_done   <= 1'b0;
            tok_len    <= '0;
            tok_cnt    <= '0;
        end else begin
            out      <= char_valid & out_nxt;
            tok_done <= char_valid & done_nxt;
            if (char_valid) begin
                state_p0 <= state_nxt;
                if (len_load)
                    run_len_p0 <= LEN_W'(1);
                else if (len_inc)
                    run_len_p0 <= len_sat_inc(run_len_p0);
                if (done_nxt)
                    tok_len <= run_len_p0;
            end
            if (cnt_clr)
                tok_cnt <= '0;
            else if (char_valid && done_nxt)
                tok_cnt <= cnt_sat_inc(tok_cnt);
        end
    end

endmodule

// File: tb/tb_id_scanner.sv
// Randomized and directed bench for id_scanner with three parameterizations
// compared against a token-level reference model.
module tb_id_scanner;

    logic       clk = 1'b0;
    logic       reset_n;
    logic [7:0] char;
    logic       char_valid;
    logic       cnt_clr;

    logic        out0, done0, out1, done1, out2, done2;
    logic [5:0]  len0, len1;
    logic [2:0]  len2;
    logic [15:0] cnt0, cnt1;
    logic [2:0]  cnt2;

    always #5 clk = ~clk;

    id_scanner #(.LEN_W(6), .CNT_W(16), .STRICT(0)) dut0 (
        .clk(clk), .reset_n(reset_n), .char(char), .char_valid(char_valid),
        .cnt_clr(cnt_clr), .out(out0), .tok_done(done0), .tok_len(len0), .tok_cnt(cnt0));

    id_scanner #(.LEN_W(6), .CNT_W(16), .STRICT(1)) dut1 (
        .clk(clk), .reset_n(reset_n), .char(char), .char_valid(char_valid),
        .cnt_clr(cnt_clr), .out(out1), .tok_done(done1), .tok_len(len1), .tok_cnt(cnt1));

    id_scanner #(.LEN_W(3), .CNT_W(3), .STRICT(0)) dut2 (
        .clk(clk), .reset_n(reset_n), .char(char), .char_valid(char_valid),
        .cnt_clr(cnt_clr), .out(out2), .tok_done(done2), .tok_len(len2), .tok_cnt(cnt2));

    int errors = 0;
    int checks = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Reference model: one entry per DUT
    int P_STRICT [3] = '{0, 1, 0};
    int P_LMAX   [3] = '{63, 63, 7};
    int P_CMAX   [3] = '{65535, 65535, 7};

    int m_run  [3];   // chars in the current candidate identifier (0 = none)
    bit m_dig  [3];   // candidate has reached its digit tail
    bit m_blk  [3];   // strict: inside a word that cannot become a token
    int m_len  [3];
    int m_cnt  [3];
    bit m_out  [3];
    bit m_done [3];

    function automatic int cls_of(input logic [7:0] c);
        if (c >= 8'h30 && c <= 8'h39) return 1;
        if ((c >= 8'h41 && c <= 8'h5A) || (c >= 8'h61 && c <= 8'h7A)) return 2;
        return 0;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 3; i++) begin
            m_run[i] = 0; m_dig[i] = 0; m_blk[i] = 0;
            m_len[i] = 0; m_cnt[i] = 0; m_out[i] = 0; m_done[i] = 0;
        end
    endtask

    task automatic end_token(input int i);
        m_done[i] = 1;
        m_len[i]  = (m_run[i] > P_LMAX[i]) ? P_LMAX[i] : m_run[i];
    endtask

    task automatic model_step(input logic [7:0] c, input bit v, input bit clr);
        for (int i = 0; i < 3; i++) begin
            m_out[i]  = 0;
            m_done[i] = 0;
            if (v) begin
                case (cls_of(c))
                    2: begin
                        if (m_dig[i]) begin
                            end_token(i);
                            m_dig[i] = 0;
                            if (P_STRICT[i] != 0) begin
                                m_blk[i] = 1;
                                m_run[i] = 0;
                            end else begin
                                m_run[i] = 1;
                            end
                        end else if (m_run[i] > 0) begin
                            m_run[i]++;
                        end else if (!m_blk[i]) begin
                            m_run[i] = 1;
                        end
                    end
                    1: begin
                        if (m_run[i] > 0) begin
                            m_out[i] = 1;
                            m_run[i]++;
                            m_dig[i] = 1;
                        end else if (P_STRICT[i] != 0) begin
                            m_blk[i] = 1;
                        end
                    end
                    default: begin
                        if (m_dig[i]) end_token(i);
                        m_run[i] = 0;
                        m_dig[i] = 0;
                        m_blk[i] = 0;
                    end
                endcase
            end
            if (clr)
                m_cnt[i] = 0;
            else if (m_done[i] && m_cnt[i] < P_CMAX[i])
                m_cnt[i]++;
        end
    endtask

    task automatic check_all();
        chk("d0.out",  32'(out0),  32'(m_out[0]));
        chk("d0.done", 32'(done0), 32'(m_done[0]));
        chk("d0.len",  32'(len0),  32'(m_len[0]));
        chk("d0.cnt",  32'(cnt0),  32'(m_cnt[0]));
        chk("d1.out",  32'(out1),  32'(m_out[1]));
        chk("d1.done", 32'(done1), 32'(m_done[1]));
        chk("d1.len",  32'(len1),  32'(m_len[1]));
        chk("d1.cnt",  32'(cnt1),  32'(m_cnt[1]));
        chk("d2.out",  32'(out2),  32'(m_out[2]));
        chk("d2.done", 32'(done2), 32'(m_done[2]));
        chk("d2.len",  32'(len2),  32'(m_len[2]));
        chk("d2.cnt",  32'(cnt2),  32'(m_cnt[2]));
    endtask

    task automatic step(input logic [7:0] c, input bit v, input bit clr);
        char       = c;
        char_valid = v;
        cnt_clr    = clr;
        @(posedge clk);
        model_step(c, v, clr);
        #1;
        check_all();
        char_valid = 1'b0;
        cnt_clr    = 1'b0;
    endtask

    task automatic send_str(input string s);
        for (int i = 0; i < s.len(); i++) step(s[i], 1'b1, 1'b0);
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        model_reset();
        #1;
        check_all();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    function automatic logic [7:0] rand_char();
        logic [7:0] bnd [8] = '{8'h2F, 8'h3A, 8'h40, 8'h5B, 8'h60, 8'h7B, 8'h00, 8'hFF};
        int r = $urandom_range(0, 9);
        if (r < 2)  return 8'h41 + 8'($urandom_range(0, 25));
        if (r < 4)  return 8'h61 + 8'($urandom_range(0, 25));
        if (r < 7)  return 8'h30 + 8'($urandom_range(0, 9));
        if (r == 7) return 8'h20;
        if (r == 8) return bnd[$urandom_range(0, 7)];
        return 8'($urandom);
    endfunction

    initial begin
        char       = 8'h00;
        char_valid = 1'b0;
        cnt_clr    = 1'b0;
        reset_n    = 1'b0;

        do_reset();
        chk("rst.len0", 32'(len0), 32'd0);
        chk("rst.cnt0", 32'(cnt0), 32'd0);

        // Basic token
        send_str("ab12 ");
        chk("basic.len", 32'(len0), 32'd4);
        chk("basic.cnt", 32'(cnt0), 32'd1);

        // Strict vs relaxed
        do_reset();
        send_str("9a1b2.");
        chk("strict0.cnt", 32'(cnt0), 32'd2);
        chk("strict0.len", 32'(len0), 32'd2);
        chk("strict1.cnt", 32'(cnt1), 32'd0);

        // Gap in char_valid
        do_reset();
        step("a", 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) step(8'h31, 1'b0, 1'b0);
        step("1", 1'b1, 1'b0);
        step(" ", 1'b1, 1'b0);
        chk("gap.len", 32'(len0), 32'd2);

        // Length saturation on the narrow instance
        do_reset();
        send_str("abcdefghij1 ");
        chk("lsat.len", 32'(len2), 32'd7);
        chk("lsat.cnt", 32'(cnt2), 32'd1);

        // Asynchronous reset mid-token discards it
        do_reset();
        send_str("x12");
        @(negedge clk);
        reset_n = 1'b0;
        model_reset();
        #1;
        chk("arst.out",  32'(out0),  32'd0);
        chk("arst.done", 32'(done0), 32'd0);
        chk("arst.len",  32'(len0),  32'd0);
        chk("arst.cnt",  32'(cnt0),  32'd0);
        repeat (2) @(posedge clk);
        #1;
        check_all();
        @(negedge clk);
        reset_n = 1'b1;
        step(" ", 1'b1, 1'b0);
        chk("arst.nodone", 32'(done0), 32'd0);

        // Clear wins over a coincident increment
        do_reset();
        for (int i = 0; i < 5; i++) send_str("a1 ");
        chk("clr.pre", 32'(cnt0), 32'd5);
        send_str("a1");
        step(" ", 1'b1, 1'b1);
        chk("clr.done", 32'(done0), 32'd1);
        chk("clr.cnt",  32'(cnt0),  32'd0);

        // Count saturation on the narrow instance
        do_reset();
        for (int i = 0; i < 9; i++) send_str("Z9;");
        chk("csat.cnt2", 32'(cnt2), 32'd7);
        chk("csat.cnt0", 32'(cnt0), 32'd9);

        // Randomized traffic
        do_reset();
        for (int n = 0; n < 3000; n++)
            step(rand_char(), $urandom_range(0, 7) != 0, $urandom_range(0, 63) == 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/id_scanner.md
ID_SCANNER -- requirements
Module: id_scanner

Interface
REQ-001 SHALL have parameter LEN_W, default 6, width of token-length field (saturating).
REQ-002 SHALL have parameter CNT_W, default 16, width of token-count register (saturating).
REQ-003 SHALL have parameter STRICT, default 0; 1 = a token may only start after a non-alphanumeric char or after reset.
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-006 SHALL have port char  input  8  ASCII character.
REQ-007 SHALL have port char_valid  input  1  char is consumed this cycle when high.
REQ-008 SHALL have port cnt_clr  input  1  synchronous clear of tok_cnt.
REQ-009 SHALL have port out  output  1  registered; high for one cycle per consumed digit that extends a letters-then-digits run.
REQ-010 SHALL have port tok_done  output  1  registered one-cycle pulse when a matched token ends.
REQ-011 SHALL have port tok_len  output  LEN_W  length of the token that ended; valid while tok_done is high, held otherwise.
REQ-012 SHALL have port tok_cnt  output  CNT_W  number of tok_done events since reset/clear.

Function
REQ-013 SHALL classify char as DIGIT (0x30-0x39), ALPHA (0x41-0x5A, 0x61-0x7A) or OTHER.
REQ-014 SHALL implement states S_IDLE, S_ALPHA, S_DIGIT, S_SKIP.
REQ-015 S_IDLE: ALPHA -> S_ALPHA; DIGIT -> S_SKIP if STRICT=1, else S_IDLE; OTHER -> S_IDLE.
REQ-016 S_ALPHA: ALPHA -> S_ALPHA; DIGIT -> S_DIGIT with out=1; OTHER -> S_IDLE.
REQ-017 S_DIGIT: DIGIT -> S_DIGIT with out=1; ALPHA -> S_ALPHA (STRICT=0) or S_SKIP (STRICT=1); OTHER -> S_IDLE.
REQ-018 S_SKIP: ALPHA/DIGIT -> S_SKIP; OTHER -> S_IDLE; never reached when STRICT=0.
REQ-019 out, tok_done SHALL assert in the cycle after the posedge that consumes the triggering char (1-cycle latency), low otherwise.
REQ-020 When char_valid=0, state, run length and outputs SHALL hold except out and tok_done, which go low.
REQ-021 Run length SHALL load 1 on entry to S_ALPHA from any other state, increment per consumed char while staying in S_ALPHA/S_DIGIT, saturate at 2^LEN_W-1.
REQ-022 Leaving S_DIGIT on any char SHALL pulse tok_done with tok_len = run length before that char (terminating char excluded).
REQ-023 tok_cnt SHALL increment on each tok_done, saturate at 2^CNT_W-1; cnt_clr same cycle as increment: clear wins.
REQ-024 ALPHA->DIGIT->ALPHA in STRICT=0 SHALL end one token and start a new run of length 1 in the same cycle.

Reset
REQ-025 reset_n low SHALL immediately force S_IDLE, run length 0, out=0, tok_done=0, tok_len=0, tok_cnt=0, independent of clk.
REQ-026 Reset mid-token SHALL discard the token: no tok_done on release; first char after release is evaluated from S_IDLE.

Structure
REQ-027 State encoding, character-class codes and ASCII range constants SHALL live in shared package id_pkg.
REQ-028 Classification SHALL be a combinational sub-module char_class (char -> 2-bit class), reused by the FSM.

Verification
REQ-029 STRICT=0, stream "ab12 " -> out high after '1' and '2'; tok_done after ' ' with tok_len=4, tok_cnt=1.
REQ-030 STRICT=0 "9a1b2." vs STRICT=1 same stream -> STRICT=0: two tokens (len 2, len 2); STRICT=1: out never high, tok_cnt=0.
REQ-031 "a1" with char_valid low 3 cycles between 'a' and '1', then ' ' -> out once, tok_len=2, no pulse during gap.
REQ-032 LEN_W=3, "abcdefghij1 " -> tok_len=7 (saturated), tok_cnt=1.
REQ-033 "x12" then reset_n low mid-stream, release, " " -> no tok_done, all outputs 0 during and after reset.
REQ-034 tok_cnt at 5, cnt_clr asserted same cycle a tok_done increments -> tok_cnt=0 next cycle.
